// File: rtl/key_beep_multi.sv
// key_beep_multi: per-key 2-flop sync + debounce, press pulses, buzzer plays i+1 bursts for key i.
// Latency: key_press 2+CNT_MAX cycles after a key falls; busy/beep rise 1 cycle after key_press.
// No backpressure: presses while busy are dropped (one-deep pending slot with KEY_BEEP_PENDING_EN).
module key_beep_multi #(
   parameter int NUM_KEYS     = 4,
   parameter int CNT_MAX      = 1000000,
   parameter int BEEP_ON_CYC  = 5000000,
   parameter int BEEP_OFF_CYC = 5000000,
   parameter int TONE_HALF    = 12500
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [NUM_KEYS-1:0] key,
   output logic [NUM_KEYS-1:0] key_filter,
   output logic [NUM_KEYS-1:0] key_press,
   output logic                busy,
   output logic                beep
);
   localparam int CW   = $clog2(CNT_MAX);
   localparam int BW   = $clog2(NUM_KEYS + 1);
   localparam int TMAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int HW   = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

   logic [NUM_KEYS-1:0] ks_meta;
   logic [NUM_KEYS-1:0] ks;
   logic [CW-1:0]       db_cnt [NUM_KEYS];

   state_t              state;
   logic [BW-1:0]       bursts_left;
   logic [TW-1:0]       timer;
   logic [HW-1:0]       tone;

   logic                press_any;
   logic [BW-1:0]       sel_bursts;
   logic                start_vld;
   logic [BW-1:0]       start_bursts;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ks_meta    <= '1;
         ks         <= '1;
         key_filter <= '1;
         key_press  <= '0;
         for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
      end else begin
         ks_meta <= key;
         ks      <= ks_meta;
         for (int i = 0; i < NUM_KEYS; i++) begin
            key_press[i] <= 1'b0;
            if (ks[i] == key_filter[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CW'(CNT_MAX - 1)) begin
               // Level accepted: pulse only when the new debounced level is "pressed".
               db_cnt[i]     <= '0;
               key_filter[i] <= ks[i];
               key_press[i]  <= ~ks[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign press_any = |key_press;

   always_comb begin
      sel_bursts = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (key_press[i]) sel_bursts = BW'(i + 1);
      end
   end

`ifdef KEY_BEEP_PENDING_EN
   logic          pend_vld;
   logic [BW-1:0] pend_bursts;

   // The slot drains on the IDLE cycle that follows the end of a pattern.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pend_vld    <= 1'b0;
         pend_bursts <= '0;
      end else if (state == IDLE) begin
         pend_vld <= 1'b0;
      end else if (press_any && !pend_vld) begin
         pend_vld    <= 1'b1;
         pend_bursts <= sel_bursts;
      end
   end

   assign start_vld    = pend_vld | press_any;
   assign start_bursts = pend_vld ? pend_bursts : sel_bursts;
`else
   assign start_vld    = press_any;
   assign start_bursts = sel_bursts;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= IDLE;
         bursts_left <= '0;
         timer       <= '0;
         tone        <= '0;
         busy        <= 1'b0;
         beep        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_vld) begin
                  state       <= ON;
                  bursts_left <= start_bursts;
                  timer       <= '0;
                  tone        <= '0;
                  busy        <= 1'b1;
                  beep        <= 1'b1;
               end
            end
            ON: begin
               if (timer == TW'(BEEP_ON_CYC - 1)) begin
                  timer       <= '0;
                  bursts_left <= bursts_left - BW'(1);
                  beep        <= 1'b0;
                  if (bursts_left == BW'(1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= OFF;
                  end
               end else begin
                  timer <= timer + TW'(1);
                  if (tone == HW'(TONE_HALF - 1)) begin
                     tone <= '0;
                     beep <= ~beep;
                  end else begin
                     tone <= tone + HW'(1);
                  end
               end
            end
            OFF: begin
               if (timer == TW'(BEEP_OFF_CYC - 1)) begin
                  state <= ON;
                  timer <= '0;
                  tone  <= '0;
                  beep  <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               beep  <= 1'b0;
            end
         endcase
      end
   end
endmodule
